program_sequencer: RTL and testbench

Control FSM for the 4-bit processor front end: the 12-bit program counter, the 4K×8 program ROM and the 8-bit fetch register. It drives the counter's enable, load and load value and the fetch register's enable, so instructions are fetched, decoded and executed in fixed phases. It resolves two-byte jump instructions from the condition flags and raises a one-cycle execute strobe for the ALU/accumulator datapath. It sits between the fetch stage and the datapath.

---
 rtl/program_sequencer_pkg.sv | 28 ++
 rtl/program_sequencer_branch_eval.sv | 32 +++
 rtl/program_sequencer.sv | 109 ++++++++++
 tb/tb_program_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/program_sequencer_pkg.sv
// program_sequencer_pkg
// Shared definitions for the 4-bit processor front end.
//   - Opcode constants. The datapath decoder uses these same values, so the
//     sequencer and the decoder always agree on which opcodes are jumps and
//     which one is HLT.
//   - State encoding of the fetch/decode/execute sequencer.
package program_sequencer_pkg;

  // Two-byte jump opcodes: target = {oprnd, second byte}
  localparam logic [3:0] OP_JC  = 4'h0;
  localparam logic [3:0] OP_JNC = 4'h1;
  localparam logic [3:0] OP_JZ  = 4'h2;
  localparam logic [3:0] OP_JNZ = 4'h3;
  localparam logic [3:0] OP_JMP = 4'hE;
  // Stop and wait for run
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_LOAD   = 3'd4,
    ST_SKIP   = 3'd5,
    ST_HALT   = 3'd6
  } state_e;

endpackage

// File: rtl/program_sequencer_branch_eval.sv
// branch_eval
// Combinational jump classifier.
// Ports:
//   instr   in  4 : opcode nibble from the fetch register
//   c_flag  in  1 : carry flag
//   z_flag  in  1 : zero flag
//   is_jump out 1 : opcode is one of the two-byte jumps
//   taken   out 1 : jump condition holds (only meaningful when is_jump=1)
module branch_eval
  import program_sequencer_pkg::*;
(
  input  logic [3:0] instr,
  input  logic       c_flag,
  input  logic       z_flag,
  output logic       is_jump,
  output logic       taken
);

  always_comb begin
    is_jump = 1'b1;
    taken   = 1'b0;
    case (instr)
      OP_JC:   taken = c_flag;
      OP_JNC:  taken = ~c_flag;
      OP_JZ:   taken = z_flag;
      OP_JNZ:  taken = ~z_flag;
      OP_JMP:  taken = 1'b1;
      default: is_jump = 1'b0;
    endcase
  end

endmodule

// File: rtl/program_sequencer.sv
// program_sequencer
// Control FSM for the 4-bit processor front end. Sequences each instruction
// through FETCH -> DECODE -> EXEC/LOAD/SKIP by driving the program counter
// and fetch register controls, resolves two-byte conditional jumps and parks
// on HLT until run is raised again.
// Ports:
//   clk          in  1      : clock, rising edge
//   rst          in  1      : asynchronous reset, active low
//   run          in  1      : start/resume request (seen in IDLE/HALT only)
//   program_byte in  8      : ROM output at the current PC
//   instr        in  4      : fetch register high nibble
//   oprnd        in  4      : fetch register low nibble
//   c_flag       in  1      : carry flag
//   z_flag       in  1      : zero flag
//   pc_enable    out 1      : PC increment enable
//   pc_load      out 1      : PC load
//   pc_loadvalue out ADDR_W : PC load value (last jump target)
//   fetch_enable out 1      : fetch register capture enable
//   exec_strobe  out 1      : one-cycle execute pulse to the datapath
//   halted       out 1      : parked on HLT
// All outputs are registers loaded from the decode of the next state, so
// each output is valid for exactly the cycle its state is occupied.
module program_sequencer
  import program_sequencer_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [7:0]        program_byte,
  input  logic [3:0]        instr,
  input  logic [3:0]        oprnd,
  input  logic              c_flag,
  input  logic              z_flag,
  output logic              pc_enable,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_loadvalue,
  output logic              fetch_enable,
  output logic              exec_strobe,
  output logic              halted
);

  state_e            state_q, state_d;
  logic              pc_enable_q, pc_load_q, fetch_enable_q, exec_strobe_q, halted_q;
  logic [ADDR_W-1:0] loadvalue_q;
  logic [ADDR_W-1:0] target_d;
  logic              is_jump, taken;

  branch_eval u_branch_eval (
    .instr   (instr),
    .c_flag  (c_flag),
    .z_flag  (z_flag),
    .is_jump (is_jump),
    .taken   (taken)
  );

  // In DECODE the PC has already stepped past the opcode byte, so the ROM
  // output is the jump's second byte (wrapping from 12'hFFF to 12'h000).
  assign target_d = ADDR_W'({oprnd, program_byte});

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (run) state_d = ST_FETCH;
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: begin
        if (is_jump)              state_d = taken ? ST_LOAD : ST_SKIP;
        else if (instr == OP_HLT) state_d = ST_HALT;
        else                      state_d = ST_EXEC;
      end
      ST_EXEC:   state_d = ST_FETCH;
      ST_LOAD:   state_d = ST_FETCH;
      ST_SKIP:   state_d = ST_FETCH;
      ST_HALT:   if (run) state_d = ST_FETCH;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      pc_enable_q    <= 1'b0;
      pc_load_q      <= 1'b0;
      fetch_enable_q <= 1'b0;
      exec_strobe_q  <= 1'b0;
      halted_q       <= 1'b0;
      loadvalue_q    <= '0;
    end else begin
      state_q        <= state_d;
      // SKIP also steps the PC: it advances over the unused second byte.
      pc_enable_q    <= (state_d == ST_FETCH) || (state_d == ST_SKIP);
      pc_load_q      <= (state_d == ST_LOAD);
      fetch_enable_q <= (state_d == ST_FETCH);
      exec_strobe_q  <= (state_d == ST_EXEC);
      halted_q       <= (state_d == ST_HALT);
      // Target is latched for every jump, taken or not.
      if (state_q == ST_DECODE && is_jump) loadvalue_q <= target_d;
    end
  end

  assign pc_enable    = pc_enable_q;
  assign pc_load      = pc_load_q;
  assign pc_loadvalue = loadvalue_q;
  assign fetch_enable = fetch_enable_q;
  assign exec_strobe  = exec_strobe_q;
  assign halted       = halted_q;

endmodule

// File: tb/tb_program_sequencer.sv
// tb_program_sequencer
// Directed bench: wraps the sequencer with a behavioural PC, 4Kx8 ROM and
// fetch register, then walks hand-computed instruction sequences.
module tb_program_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run = 1'b0;
  logic        c_flag = 1'b0;
  logic        z_flag = 1'b0;
  logic [7:0]  program_byte;
  logic [3:0]  instr, oprnd;
  logic        pc_enable, pc_load, fetch_enable, exec_strobe, halted;
  logic [11:0] pc_loadvalue;

  logic [7:0]  rom [4096];
  logic [11:0] pc;
  logic [11:0] pc_start = 12'h000;
  logic [7:0]  fetch_reg;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Fetch stage model: PC restarts at pc_start on reset.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc        <= pc_start;
      fetch_reg <= 8'h00;
    end else begin
      if (pc_load)        pc <= pc_loadvalue;
      else if (pc_enable) pc <= pc + 12'd1;
      if (fetch_enable)   fetch_reg <= rom[pc];
    end
  end

  assign program_byte = rom[pc];
  assign instr        = fetch_reg[7:4];
  assign oprnd        = fetch_reg[3:0];

  program_sequencer #(.ADDR_W(12)) dut (
    .clk          (clk),
    .rst          (rst),
    .run          (run),
    .program_byte (program_byte),
    .instr        (instr),
    .oprnd        (oprnd),
    .c_flag       (c_flag),
    .z_flag       (z_flag),
    .pc_enable    (pc_enable),
    .pc_load      (pc_load),
    .pc_loadvalue (pc_loadvalue),
    .fetch_enable (fetch_enable),
    .exec_strobe  (exec_strobe),
    .halted       (halted)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  // Output vector order: {pc_enable, pc_load, fetch_enable, exec_strobe, halted}
  localparam logic [4:0] O_NONE  = 5'b00000;
  localparam logic [4:0] O_FETCH = 5'b10100;
  localparam logic [4:0] O_EXEC  = 5'b00010;
  localparam logic [4:0] O_LOAD  = 5'b01000;
  localparam logic [4:0] O_SKIP  = 5'b10000;
  localparam logic [4:0] O_HALT  = 5'b00001;

  task automatic chk_out(input string tag, input logic [4:0] exp);
    chk(tag, {27'd0, pc_enable, pc_load, fetch_enable, exec_strobe, halted}, {27'd0, exp});
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
  endtask

  // Hold reset for two edges, then release at a falling edge with run=1.
  task automatic restart(input logic [11:0] start);
    rst      = 1'b0;
    run      = 1'b0;
    pc_start = start;
    step();
    step();
    rst = 1'b1;
    run = 1'b1;
  endtask

  initial begin
    clear_rom();
    step();
    chk_out("reset_outputs", O_NONE);
    chk("reset_loadvalue", {20'd0, pc_loadvalue}, 32'h0);

    // Single-byte instruction 5A
    rom[0] = 8'h5A;
    restart(12'h000);
    step(); chk_out("t1_fetch", O_FETCH); run = 1'b0;
    step(); chk_out("t1_decode", O_NONE);
    chk("t1_instr", {28'd0, instr}, 32'h5);
    chk("t1_oprnd", {28'd0, oprnd}, 32'hA);
    step(); chk_out("t1_exec", O_EXEC);
    step(); chk_out("t1_fetch2", O_FETCH);
    chk("t1_pc", {20'd0, pc}, 32'h001);

    // JMP 123
    clear_rom();
    rom[0] = 8'hE1; rom[1] = 8'h23; rom[12'h123] = 8'h5B;
    restart(12'h000);
    step(); chk_out("t2_fetch", O_FETCH); run = 1'b0;
    step(); chk_out("t2_decode", O_NONE);
    step(); chk_out("t2_load", O_LOAD);
    chk("t2_target", {20'd0, pc_loadvalue}, 32'h123);
    step(); chk_out("t2_fetch2", O_FETCH);
    chk("t2_pc", {20'd0, pc}, 32'h123);
    step(); chk("t2_fetched", {24'd0, fetch_reg}, 32'h5B);

    // JC 456 not taken, then taken
    clear_rom();
    rom[0] = 8'h04; rom[1] = 8'h56;
    c_flag = 1'b0;
    restart(12'h000);
    step(); chk_out("t3_fetch", O_FETCH); run = 1'b0;
    step(); chk_out("t3_decode", O_NONE);
    step(); chk_out("t3_skip", O_SKIP);
    step(); chk_out("t3_fetch2", O_FETCH);
    chk("t3_pc", {20'd0, pc}, 32'h002);
    c_flag = 1'b1;
    restart(12'h000);
    step(); chk_out("t3c_fetch", O_FETCH); run = 1'b0;
    step(); chk_out("t3c_decode", O_NONE);
    step(); chk_out("t3c_load", O_LOAD);
    chk("t3c_target", {20'd0, pc_loadvalue}, 32'h456);
    c_flag = 1'b0;

    // JZ / JNZ on the zero flag: 2x with Z=1 taken, 3x with Z=1 skipped
    clear_rom();
    rom[0] = 8'h27; rom[1] = 8'h89;
    z_flag = 1'b1;
    restart(12'h000);
    step(); run = 1'b0;
    step();
    step(); chk_out("t3z_jz_load", O_LOAD);
    chk("t3z_jz_target", {20'd0, pc_loadvalue}, 32'h789);
    rom[0] = 8'h31;
    restart(12'h000);
    step(); run = 1'b0;
    step();
    step(); chk_out("t3z_jnz_skip", O_SKIP);
    z_flag = 1'b0;

    // HLT
    clear_rom();
    rom[0] = 8'hF0;
    restart(12'h000);
    step(); chk_out("t4_fetch", O_FETCH); run = 1'b0;
    step(); chk_out("t4_decode", O_NONE);
    for (int i = 0; i < 10; i++) begin
      step(); chk_out($sformatf("t4_halt%0d", i), O_HALT);
    end
    run = 1'b1;
    step(); chk_out("t4_resume", O_FETCH);
    chk("t4_pc", {20'd0, pc}, 32'h001);
    run = 1'b0;

    // Wrap-around: JMP at FFF takes second byte from 000
    clear_rom();
    rom[12'hFFF] = 8'hEF; rom[0] = 8'h77;
    restart(12'hFFF);
    step(); chk_out("t5_fetch", O_FETCH); run = 1'b0;
    step(); chk("t5_pc_wrap", {20'd0, pc}, 32'h000);
    step(); chk_out("t5_load", O_LOAD);
    chk("t5_target", {20'd0, pc_loadvalue}, 32'hF77);
    // JNC at FFF not taken: SKIP lands on 001, target still latched
    rom[12'hFFF] = 8'h1A;
    c_flag = 1'b1;
    restart(12'hFFF);
    step(); run = 1'b0;
    step();
    step(); chk_out("t5_skip", O_SKIP);
    chk("t5_skip_target", {20'd0, pc_loadvalue}, 32'hA77);
    step(); chk("t5_skip_pc", {20'd0, pc}, 32'h001);
    c_flag = 1'b0;

    // Reset asserted in the middle of LOAD
    clear_rom();
    rom[0] = 8'hE1; rom[1] = 8'h23;
    restart(12'h000);
    step(); run = 1'b0;
    step();
    step(); chk_out("t6_load", O_LOAD);
    #2 rst = 1'b0;
    #1 chk_out("t6_rst_out", O_NONE);
    chk("t6_rst_target", {20'd0, pc_loadvalue}, 32'h0);
    step(); chk_out("t6_rst_hold", O_NONE);
    chk("t6_pc", {20'd0, pc}, 32'h000);
    rst = 1'b1;
    step(); chk_out("t6_idle", O_NONE);
    step(); chk_out("t6_idle2", O_NONE);
    run = 1'b1;
    step(); chk_out("t6_restart", O_FETCH);
    chk("t6_restart_pc", {20'd0, pc}, 32'h000);
    run = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Mutually exclusive output pairs, checked every cycle after reset.
  always @(negedge clk) begin
    if (rst && (pc_load && pc_enable)) begin
      bad++;
      $display("FAIL excl_load_enable: got both 1 expected not both");
    end
    if (rst && (exec_strobe && fetch_enable)) begin
      bad++;
      $display("FAIL excl_exec_fetch: got both 1 expected not both");
    end
  end

endmodule
